ldm_stm_sequencer: RTL

- Multi-cycle block-transfer sequencer for LDM/STM.
- Walks a 16-bit register list and drives the register-file read port (STM) or write port (LDM), one register per memory transaction.
- Sits between the decode/control unit, the register file and the data-memory port; stalls the core via busy_o.
- r15 is not stored in the register file: r15 is read from pc_i and a load to r15 is redirected to pc_write_o.

---
 rtl/ldm_stm_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks a register list one memory transaction at a time,
// driving the register-file ports, redirecting r15 to the PC, and writing back the new base.
module ldm_stm_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              load_i,
  input  logic [15:0]       reg_list_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [3:0]        base_reg_i,
  input  logic              increment_i,
  input  logic              before_i,
  input  logic              writeback_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        rf_read_addr_o,
  input  logic [DATA_W-1:0] rf_read_data_i,
  output logic              rf_write_enable_o,
  output logic [3:0]        rf_write_addr_o,
  output logic [DATA_W-1:0] rf_write_data_o,
  output logic              pc_write_o,
  output logic [DATA_W-1:0] pc_data_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i
);

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StLdwr, StWback, StDone} state_t;

  state_t            r_state, w_state_next;
  logic              r_load, r_inc, r_before, r_wb, r_wb_en, r_issue;
  logic [15:0]       r_list;
  logic [3:0]        r_cursor, r_base_reg;
  logic [ADDR_W-1:0] r_base, r_addr, r_new_base;
  logic [DATA_W-1:0] r_wdata, r_rdata;

  logic [4:0]        w_n;
  logic [ADDR_W-1:0] w_four_n, w_start_addr, w_new_base;
  logic [15:0]       w_list_clr;
  logic              w_done_xfer;

  function automatic logic [3:0] f_lowest(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_comb begin
    w_n = '0;
    for (int i = 0; i < 16; i++) begin
      w_n = w_n + 5'(r_list[i]);
    end
  end

  assign w_four_n    = ADDR_W'({w_n, 2'b00});
  assign w_new_base  = r_inc ? r_base + w_four_n : r_base - w_four_n;
  assign w_list_clr  = r_list & ~(16'd1 << r_cursor);
  assign w_done_xfer = r_issue && mem_ready_i;

  // Lowest register always lands on the lowest address in every mode.
  always_comb begin
    unique case ({r_inc, r_before})
      2'b10:   w_start_addr = r_base;
      2'b11:   w_start_addr = r_base + ADDR_W'(4);
      2'b00:   w_start_addr = r_base - w_four_n + ADDR_W'(4);
      default: w_start_addr = r_base - w_four_n;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start_i) w_state_next = StSetup;
      StSetup: w_state_next = (w_n == 5'd0) ? StDone : StXfer;
      StXfer: begin
        if (w_done_xfer) begin
          if (r_load)                  w_state_next = StLdwr;
          else if (w_list_clr != 16'd0) w_state_next = StXfer;
          else                         w_state_next = StWback;
        end
      end
      StLdwr:  w_state_next = (r_list != 16'd0) ? StXfer : StWback;
      StWback: w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // r_issue splits each transfer into a request-low prep cycle and the request phase.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_load     <= 1'b0;
      r_inc      <= 1'b0;
      r_before   <= 1'b0;
      r_wb       <= 1'b0;
      r_wb_en    <= 1'b0;
      r_issue    <= 1'b0;
      r_list     <= '0;
      r_cursor   <= '0;
      r_base_reg <= '0;
      r_base     <= '0;
      r_addr     <= '0;
      r_new_base <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            r_load     <= load_i;
            r_list     <= reg_list_i;
            r_base     <= base_addr_i;
            r_base_reg <= base_reg_i;
            r_inc      <= increment_i;
            r_before   <= before_i;
            r_wb       <= writeback_i;
          end
        end
        StSetup: begin
          r_addr     <= w_start_addr;
          r_new_base <= w_new_base;
          r_cursor   <= f_lowest(r_list);
          r_issue    <= 1'b0;
          r_wb_en    <= r_wb && (w_n != 5'd0) && (r_base_reg != 4'd15) &&
                        !(r_load && r_list[r_base_reg]);
        end
        StXfer: begin
          if (!r_issue) begin
            r_issue <= 1'b1;
            if (!r_load) begin
              r_wdata <= (r_cursor == 4'd15) ? pc_i + DATA_W'(8) : rf_read_data_i;
            end
          end else if (mem_ready_i) begin
            r_issue <= 1'b0;
            r_list  <= w_list_clr;
            r_addr  <= r_addr + ADDR_W'(4);
            if (r_load) r_rdata <= mem_rdata_i;
            else        r_cursor <= f_lowest(w_list_clr);
          end
        end
        StLdwr:  r_cursor <= f_lowest(r_list);
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o            = 1'b0;
    done_o            = 1'b0;
    rf_read_addr_o    = '0;
    rf_write_enable_o = 1'b0;
    rf_write_addr_o   = '0;
    rf_write_data_o   = '0;
    pc_write_o        = 1'b0;
    pc_data_o         = '0;
    mem_req_o         = 1'b0;
    mem_we_o          = 1'b0;
    mem_addr_o        = '0;
    mem_wdata_o       = '0;
    unique case (r_state)
      StSetup: busy_o = 1'b1;
      StXfer: begin
        busy_o = 1'b1;
        if (!r_load) rf_read_addr_o = r_cursor;
        if (r_issue) begin
          mem_req_o  = 1'b1;
          mem_we_o   = !r_load;
          mem_addr_o = {r_addr[ADDR_W-1:2], 2'b00};
          if (!r_load) mem_wdata_o = r_wdata;
        end
      end
      StLdwr: begin
        busy_o = 1'b1;
        if (r_cursor == 4'd15) begin
          pc_write_o = 1'b1;
          pc_data_o  = r_rdata & ~DATA_W'(3);
        end else begin
          rf_write_enable_o = 1'b1;
          rf_write_addr_o   = r_cursor;
          rf_write_data_o   = r_rdata;
        end
      end
      StWback: begin
        busy_o = 1'b1;
        if (r_wb_en) begin
          rf_write_enable_o = 1'b1;
          rf_write_addr_o   = r_base_reg;
          rf_write_data_o   = DATA_W'(r_new_base);
        end
      end
      StDone:  done_o = 1'b1;
      default: ;
    endcase
  end

endmodule
